// File: rtl/vga_layer_scanner.sv
// vga_layer_scanner: raster scan over the active frame, per-pixel hit test of
// NUM_LAYERS rectangular layers and priority composite down to one SDRAM byte
// address (or a background flag) per pixel. The pipeline has three stages:
// S1 holds the scan position, the S2 registers hold the per-layer hit results and
// addresses, and S3 holds the selected pixel on the outputs.
module vga_layer_scanner #(
    parameter int NUM_LAYERS = 8,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int COORD_W    = 11,
    parameter int ADDR_W     = 26,
    localparam int LB        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hwregs_vga_select,
    input  logic [8:0]        hwregs_addr,
    input  logic [25:0]       hwregs_wdata,
    input  logic              frame_start,
    input  logic              stall,
    input  logic              fifo_full,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_hit,
    output logic [LB-1:0]     pix_layer,
    output logic              pix_eol,
    output logic              frame_done,
    output logic              busy
);

    typedef struct packed {
        logic [ADDR_W-1:0]  base;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y2;
        logic [ADDR_W-1:0]  stride;
        logic               en;
    } layer_t;

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_H - 1);

    // register file: shadow copy written by the bus, live copy used by the scan
    layer_t             shadow_q [NUM_LAYERS];
    layer_t             shadow_d [NUM_LAYERS];
    layer_t             live_q   [NUM_LAYERS];
    layer_t             live_d   [NUM_LAYERS];
    logic [ADDR_W-1:0]  row_ptr_q [NUM_LAYERS];
    logic [ADDR_W-1:0]  row_ptr_d [NUM_LAYERS];

    // S1 scan position
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               running_q, running_d;

    // S2 per-layer hit results
    logic                  s2_valid_q, s2_valid_d;
    logic [NUM_LAYERS-1:0] s2_hit_q, s2_hit_d;
    logic [ADDR_W-1:0]     s2_addr_q [NUM_LAYERS];
    logic [ADDR_W-1:0]     s2_addr_d [NUM_LAYERS];
    logic                  s2_eol_q, s2_eol_d, s2_last_q, s2_last_d;

    // S3 selected pixel (registered outputs)
    logic              pix_valid_q, pix_valid_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic              pix_hit_q, pix_hit_d;
    logic [LB-1:0]     pix_layer_q, pix_layer_d;
    logic              pix_eol_q, pix_eol_d;
    logic              frame_done_q, frame_done_d;

    logic [2:0]            wr_reg;
    logic [LB-1:0]         wr_layer;
    logic                  issue;
    logic [NUM_LAYERS-1:0] in_rows;
    logic [NUM_LAYERS-1:0] hit_now;
    logic [ADDR_W-1:0]     addr_now [NUM_LAYERS];
    logic                  unused_bus_bits;

    assign wr_reg          = hwregs_addr[2:0];
    assign wr_layer        = hwregs_addr[3 +: LB];
    assign unused_bus_bits = ^{hwregs_addr[8:3+LB], hwregs_wdata};
    assign issue           = running_q && !fifo_full && !stall;

    // per-layer hit test and address for the pixel currently at S1
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
        assign in_rows[gi]  = (y_q >= live_q[gi].y1) && (y_q < live_q[gi].y2);
        assign hit_now[gi]  = live_q[gi].en && in_rows[gi] &&
                              (x_q >= live_q[gi].x1) && (x_q < live_q[gi].x2);
        assign addr_now[gi] = row_ptr_q[gi] + ADDR_W'(x_q - live_q[gi].x1);
    end

    // next-state logic for register file, scan, hit stage and select stage
    always_comb begin
        shadow_d     = shadow_q;
        live_d       = live_q;
        row_ptr_d    = row_ptr_q;
        x_d          = x_q;
        y_d          = y_q;
        running_d    = running_q;
        s2_valid_d   = s2_valid_q;
        s2_hit_d     = s2_hit_q;
        s2_addr_d    = s2_addr_q;
        s2_eol_d     = s2_eol_q;
        s2_last_d    = s2_last_q;
        pix_valid_d  = pix_valid_q;
        pix_addr_d   = pix_addr_q;
        pix_hit_d    = pix_hit_q;
        pix_layer_d  = pix_layer_q;
        pix_eol_d    = pix_eol_q;
        frame_done_d = frame_done_q;

        // bus writes always land in the shadow copy; unknown layers match nothing
        for (int l = 0; l < NUM_LAYERS; l++) begin
            if (hwregs_vga_select && (wr_layer == LB'(l))) begin
                case (wr_reg)
                    3'd0: shadow_d[l].base   = hwregs_wdata[ADDR_W-1:0];
                    3'd1: shadow_d[l].x1     = hwregs_wdata[COORD_W-1:0];
                    3'd2: shadow_d[l].y1     = hwregs_wdata[COORD_W-1:0];
                    3'd3: shadow_d[l].x2     = hwregs_wdata[COORD_W-1:0];
                    3'd4: shadow_d[l].y2     = hwregs_wdata[COORD_W-1:0];
                    3'd5: shadow_d[l].stride = hwregs_wdata[ADDR_W-1:0];
                    3'd6: shadow_d[l].en     = hwregs_wdata[0];
                    default: ;
                endcase
            end
        end

        if (frame_start) begin
            // restart: the pre-write shadow goes live, in-flight pixels are dropped
            live_d       = shadow_q;
            for (int l = 0; l < NUM_LAYERS; l++) begin
                row_ptr_d[l] = shadow_q[l].base;
            end
            x_d          = '0;
            y_d          = '0;
            running_d    = 1'b1;
            s2_valid_d   = 1'b0;
            pix_valid_d  = 1'b0;
            pix_addr_d   = '0;
            pix_hit_d    = 1'b0;
            pix_layer_d  = '0;
            pix_eol_d    = 1'b0;
            frame_done_d = 1'b0;
        end else if (stall) begin
            // S1/S2 freeze; the output shows a bubble so no pixel is presented twice
            pix_valid_d  = 1'b0;
            pix_eol_d    = 1'b0;
            frame_done_d = 1'b0;
        end else begin
            if (issue) begin
                if (x_q == X_LAST) begin
                    x_d = '0;
                    for (int l = 0; l < NUM_LAYERS; l++) begin
                        if (in_rows[l]) begin
                            row_ptr_d[l] = row_ptr_q[l] + live_q[l].stride;
                        end
                    end
                    if (y_q == Y_LAST) begin
                        y_d       = '0;
                        running_d = 1'b0;
                    end else begin
                        y_d = y_q + COORD_W'(1);
                    end
                end else begin
                    x_d = x_q + COORD_W'(1);
                end
            end

            s2_valid_d = issue;
            s2_hit_d   = hit_now;
            s2_addr_d  = addr_now;
            s2_eol_d   = (x_q == X_LAST);
            s2_last_d  = (x_q == X_LAST) && (y_q == Y_LAST);

            // ascending scan so the highest-index hitting layer wins
            pix_valid_d  = s2_valid_q;
            pix_eol_d    = s2_valid_q && s2_eol_q;
            frame_done_d = s2_valid_q && s2_last_q;
            pix_hit_d    = 1'b0;
            pix_addr_d   = '0;
            pix_layer_d  = '0;
            for (int l = 0; l < NUM_LAYERS; l++) begin
                if (s2_valid_q && s2_hit_q[l]) begin
                    pix_hit_d   = 1'b1;
                    pix_addr_d  = s2_addr_q[l];
                    pix_layer_d = LB'(l);
                end
            end
        end
    end

    // state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q     <= '{default: '0};
            live_q       <= '{default: '0};
            row_ptr_q    <= '{default: '0};
            x_q          <= '0;
            y_q          <= '0;
            running_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_hit_q     <= '0;
            s2_addr_q    <= '{default: '0};
            s2_eol_q     <= 1'b0;
            s2_last_q    <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_addr_q   <= '0;
            pix_hit_q    <= 1'b0;
            pix_layer_q  <= '0;
            pix_eol_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            live_q       <= live_d;
            row_ptr_q    <= row_ptr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            running_q    <= running_d;
            s2_valid_q   <= s2_valid_d;
            s2_hit_q     <= s2_hit_d;
            s2_addr_q    <= s2_addr_d;
            s2_eol_q     <= s2_eol_d;
            s2_last_q    <= s2_last_d;
            pix_valid_q  <= pix_valid_d;
            pix_addr_q   <= pix_addr_d;
            pix_hit_q    <= pix_hit_d;
            pix_layer_q  <= pix_layer_d;
            pix_eol_q    <= pix_eol_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_addr   = pix_addr_q;
    assign pix_hit    = pix_hit_q;
    assign pix_layer  = pix_layer_q;
    assign pix_eol    = pix_eol_q;
    assign frame_done = frame_done_q;
    assign busy       = running_q | s2_valid_q | pix_valid_q;

endmodule

// File: tb/tb_vga_layer_scanner.sv
// Bench for vga_layer_scanner on a reduced 16x8 frame. Every pixel of a frame is
// compared against a model that composites the layers directly from their
// rectangles (address = base + rows_into_layer*stride + cols_into_layer).
module tb_vga_layer_scanner;

    localparam int NL   = 8;
    localparam int W    = 16;
    localparam int H    = 8;
    localparam int CW   = 11;
    localparam int AW   = 26;
    localparam int LB   = 3;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          hwregs_vga_select = 1'b0;
    logic [8:0]    hwregs_addr = '0;
    logic [25:0]   hwregs_wdata = '0;
    logic          frame_start = 1'b0;
    logic          stall = 1'b0;
    logic          fifo_full = 1'b0;
    logic          pix_valid;
    logic [AW-1:0] pix_addr;
    logic          pix_hit;
    logic [LB-1:0] pix_layer;
    logic          pix_eol;
    logic          frame_done;
    logic          busy;

    vga_layer_scanner #(
        .NUM_LAYERS(NL), .SCREEN_W(W), .SCREEN_H(H), .COORD_W(CW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .hwregs_vga_select(hwregs_vga_select), .hwregs_addr(hwregs_addr),
        .hwregs_wdata(hwregs_wdata), .frame_start(frame_start),
        .stall(stall), .fifo_full(fifo_full),
        .pix_valid(pix_valid), .pix_addr(pix_addr), .pix_hit(pix_hit),
        .pix_layer(pix_layer), .pix_eol(pix_eol), .frame_done(frame_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          hit;
        logic [LB-1:0] layer;
        logic          eol;
        logic          done;
    } pix_t;

    pix_t got_q[$];
    pix_t exp_q[$];
    pix_t ref_q[$];
    int   tests = 0;
    int   fails = 0;

    // model register file: [layer][reg], reg 0 base .. 6 enable
    longint sh[NL][8];
    longint lv[NL][8];

    // capture every presented pixel
    always @(negedge clk) begin
        if (reset_n && pix_valid) got_q.push_back({pix_addr, pix_hit, pix_layer, pix_eol, frame_done});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int l = 0; l < NL; l++)
            for (int r = 0; r < 8; r++) begin
                sh[l][r] = 0;
                lv[l][r] = 0;
            end
    endtask

    task automatic model_write(input int l, input int r, input logic [25:0] d);
        case (r)
            0, 5:       sh[l][r] = longint'(d);
            1, 2, 3, 4: sh[l][r] = longint'(d) & 'h7ff;
            6:          sh[l][r] = longint'(d) & 1;
            default: ;
        endcase
    endtask

    task automatic model_go_live();
        for (int l = 0; l < NL; l++)
            for (int r = 0; r < 8; r++) lv[l][r] = sh[l][r];
    endtask

    function automatic pix_t model_pix(input int x, input int y);
        pix_t   p;
        longint a;
        p      = '0;
        p.eol  = (x == W - 1);
        p.done = (x == W - 1) && (y == H - 1);
        for (int l = NL - 1; l >= 0; l--) begin
            if (lv[l][6] == 1 && lv[l][1] <= x && x < lv[l][3] && lv[l][2] <= y && y < lv[l][4]) begin
                a       = lv[l][0] + (y - lv[l][2]) * lv[l][5] + (x - lv[l][1]);
                p.hit   = 1'b1;
                p.layer = LB'(l);
                p.addr  = AW'(a);
                break;
            end
        end
        return p;
    endfunction

    task automatic build_exp();
        exp_q.delete();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) exp_q.push_back(model_pix(x, y));
    endtask

    task automatic write_reg(input int l, input int r, input logic [25:0] d);
        hwregs_vga_select = 1'b1;
        hwregs_addr       = 9'((l << 3) | r);
        hwregs_wdata      = d;
        tick();
        hwregs_vga_select = 1'b0;
        model_write(l, r, d);
    endtask

    // pulse frame_start and scan until frame_done; optional write at cycle wr_cyc
    task automatic run_frame(input bit bp, input int wr_cyc, input int wr_l, input int wr_r,
                             input logic [25:0] wr_d, output int first_cyc);
        int cyc;
        bit done;
        frame_start = 1'b1;
        model_go_live();
        if (wr_cyc == 0) begin
            hwregs_vga_select = 1'b1;
            hwregs_addr       = 9'((wr_l << 3) | wr_r);
            hwregs_wdata      = wr_d;
            model_write(wr_l, wr_r, wr_d);
        end
        tick();
        frame_start       = 1'b0;
        hwregs_vga_select = 1'b0;
        got_q.delete();
        cyc       = 1;
        first_cyc = -1;
        done      = 1'b0;
        if (pix_valid) first_cyc = 1;
        while (!done && cyc < NPIX * 8 + 50) begin
            if (bp) begin
                stall     = ($urandom_range(0, 3) == 0);
                fifo_full = ($urandom_range(0, 3) == 0);
            end
            if (cyc == wr_cyc) begin
                hwregs_vga_select = 1'b1;
                hwregs_addr       = 9'((wr_l << 3) | wr_r);
                hwregs_wdata      = wr_d;
                model_write(wr_l, wr_r, wr_d);
            end
            tick();
            cyc++;
            hwregs_vga_select = 1'b0;
            if (pix_valid && first_cyc < 0) first_cyc = cyc;
            if (pix_valid && frame_done) done = 1'b1;
        end
        stall     = 1'b0;
        fifo_full = 1'b0;
        tests++;
        if (!done) begin
            fails++;
            $display("[TB] FAIL frame_timeout: frame_done seen=%0d required=1 after %0d cycles", done, cyc);
        end
        tick();
        tick();
    endtask

    task automatic check_frame(input string name);
        tests++;
        if (got_q.size() != NPIX) begin
            fails++;
            $display("[TB] FAIL %s_count: got %0d pixels, required %0d", name, got_q.size(), NPIX);
        end
        for (int i = 0; i < NPIX && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL %s_pix(%0d,%0d): got addr=%h hit=%0d layer=%0d eol=%0d done=%0d, required addr=%h hit=%0d layer=%0d eol=%0d done=%0d",
                         name, i % W, i / W, got_q[i].addr, got_q[i].hit, got_q[i].layer, got_q[i].eol,
                         got_q[i].done, exp_q[i].addr, exp_q[i].hit, exp_q[i].layer, exp_q[i].eol, exp_q[i].done);
            end
        end
        $display("[TB] %s: %0d pixels compared", name, got_q.size());
    endtask

    task automatic check_outputs_zero(input string name);
        tests++;
        if ({pix_valid, pix_addr, pix_hit, pix_layer, pix_eol, frame_done, busy} !== '0) begin
            fails++;
            $display("[TB] FAIL %s: got valid=%0d addr=%h hit=%0d layer=%0d eol=%0d done=%0d busy=%0d, required all 0",
                     name, pix_valid, pix_addr, pix_hit, pix_layer, pix_eol, frame_done, busy);
        end
    endtask

    task automatic disable_all();
        for (int l = 0; l < NL; l++) write_reg(l, 6, 26'd0);
    endtask

    task automatic test_reset();
        model_clear();
        reset_n = 1'b0;
        #12;
        check_outputs_zero("reset_outputs");
        tick();
        reset_n = 1'b1;
        tick();
        check_outputs_zero("idle_after_reset");
        $display("[TB] test_reset done");
    endtask

    task automatic test_empty_frame();
        int first;
        int eols;
        int dones;
        run_frame(1'b0, -1, 0, 0, 26'd0, first);
        build_exp();
        tests++;
        if (first != 3) begin
            fails++;
            $display("[TB] FAIL first_pixel_latency: got cycle %0d, required 3", first);
        end
        eols  = 0;
        dones = 0;
        foreach (got_q[i]) begin
            if (got_q[i].eol) eols++;
            if (got_q[i].done) dones++;
        end
        tests++;
        if (eols != H) begin
            fails++;
            $display("[TB] FAIL eol_count: got %0d, required %0d", eols, H);
        end
        tests++;
        if (dones != 1) begin
            fails++;
            $display("[TB] FAIL frame_done_count: got %0d, required 1", dones);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL busy_after_frame: got %0d, required 0", busy);
        end
        check_frame("empty");
    endtask

    task automatic test_full_layer();
        int first;
        write_reg(0, 0, 26'h1000);
        write_reg(0, 1, 26'd0);
        write_reg(0, 2, 26'd0);
        write_reg(0, 3, 26'(W));
        write_reg(0, 4, 26'(H));
        write_reg(0, 5, 26'd640);
        write_reg(0, 6, 26'd1);
        run_frame(1'b0, -1, 0, 0, 26'd0, first);
        build_exp();
        tests++;
        if (got_q.size() <= 2 * W + 5 || got_q[2 * W + 5].addr !== 26'h1505 || got_q[2 * W + 5].hit !== 1'b1) begin
            fails++;
            $display("[TB] FAIL full_layer_pix_5_2: got size=%0d addr=%h, required addr=1505 hit=1",
                     got_q.size(), (got_q.size() > 2 * W + 5) ? got_q[2 * W + 5].addr : '0);
        end
        check_frame("full_layer");
    endtask

    task automatic test_overlap();
        int first;
        disable_all();
        write_reg(2, 0, 26'h2000); write_reg(2, 1, 26'd2); write_reg(2, 2, 26'd2);
        write_reg(2, 3, 26'd10);   write_reg(2, 4, 26'd6); write_reg(2, 5, 26'd100);
        write_reg(2, 6, 26'd1);
        write_reg(5, 0, 26'h8000); write_reg(5, 1, 26'd6); write_reg(5, 2, 26'd4);
        write_reg(5, 3, 26'd14);   write_reg(5, 4, 26'd8); write_reg(5, 5, 26'd50);
        write_reg(5, 6, 26'd1);
        run_frame(1'b0, -1, 0, 0, 26'd0, first);
        build_exp();
        tests++;
        if (got_q.size() <= 5 * W + 7 || got_q[5 * W + 7].layer !== 3'd5 || got_q[5 * W + 7].addr !== 26'h8033) begin
            fails++;
            $display("[TB] FAIL overlap_pix_7_5: got layer=%0d addr=%h, required layer=5 addr=8033",
                     (got_q.size() > 5 * W + 7) ? got_q[5 * W + 7].layer : '0,
                     (got_q.size() > 5 * W + 7) ? got_q[5 * W + 7].addr : '0);
        end
        tests++;
        if (got_q.size() <= 3 * W + 3 || got_q[3 * W + 3].layer !== 3'd2 || got_q[3 * W + 3].addr !== 26'h2065) begin
            fails++;
            $display("[TB] FAIL overlap_pix_3_3: got layer=%0d addr=%h, required layer=2 addr=2065",
                     (got_q.size() > 3 * W + 3) ? got_q[3 * W + 3].layer : '0,
                     (got_q.size() > 3 * W + 3) ? got_q[3 * W + 3].addr : '0);
        end
        check_frame("overlap");
    endtask

    task automatic test_backpressure();
        int first;
        for (int l = 0; l < NL; l++) begin
            write_reg(l, 0, 26'($urandom));
            write_reg(l, 1, 26'($urandom_range(0, W + 2)));
            write_reg(l, 2, 26'($urandom_range(0, H + 2)));
            write_reg(l, 3, 26'($urandom_range(0, W + 2)));
            write_reg(l, 4, 26'($urandom_range(0, H + 2)));
            write_reg(l, 5, 26'($urandom_range(0, 5000)));
            write_reg(l, 6, 26'($urandom_range(0, 3) != 0));
        end
        run_frame(1'b0, -1, 0, 0, 26'd0, first);
        build_exp();
        check_frame("random_nobp");
        ref_q = got_q;
        run_frame(1'b1, -1, 0, 0, 26'd0, first);
        build_exp();
        check_frame("random_bp");
        tests++;
        if (got_q != ref_q) begin
            fails++;
            $display("[TB] FAIL bp_sequence: got %0d pixels differing from the no-backpressure run of %0d",
                     got_q.size(), ref_q.size());
        end
    endtask

    task automatic test_shadow();
        int first;
        disable_all();
        write_reg(1, 0, 26'h100); write_reg(1, 1, 26'd0); write_reg(1, 2, 26'd0);
        write_reg(1, 3, 26'(W));  write_reg(1, 4, 26'(H)); write_reg(1, 5, 26'(W));
        write_reg(1, 6, 26'd1);
        run_frame(1'b0, NPIX / 2, 1, 0, 26'h5000, first);
        build_exp();
        check_frame("shadow_frame_n");
        run_frame(1'b0, 0, 1, 0, 26'h9000, first);
        build_exp();
        check_frame("shadow_frame_n1");
        tests++;
        if (got_q.size() == 0 || got_q[0].addr !== 26'h5000) begin
            fails++;
            $display("[TB] FAIL shadow_new_base: got addr=%h, required 5000",
                     (got_q.size() > 0) ? got_q[0].addr : '0);
        end
        run_frame(1'b0, -1, 0, 0, 26'd0, first);
        build_exp();
        check_frame("shadow_coincident");
    endtask

    task automatic test_abort();
        int first;
        frame_start = 1'b1;
        model_go_live();
        tick();
        frame_start = 1'b0;
        repeat (NPIX / 2 + 5) tick();
        run_frame(1'b0, -1, 0, 0, 26'd0, first);
        build_exp();
        tests++;
        if (first != 3) begin
            fails++;
            $display("[TB] FAIL abort_restart_latency: got cycle %0d, required 3", first);
        end
        check_frame("abort_restart");
    endtask

    task automatic test_reset_mid();
        int first;
        frame_start = 1'b1;
        model_go_live();
        tick();
        frame_start = 1'b0;
        repeat (NPIX / 2) tick();
        reset_n = 1'b0;
        #2;
        check_outputs_zero("reset_mid_frame");
        model_clear();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        run_frame(1'b0, -1, 0, 0, 26'd0, first);
        build_exp();
        check_frame("after_reset_layers_off");
    endtask

    initial begin
        test_reset();
        test_empty_frame();
        test_full_layer();
        test_overlap();
        test_backpressure();
        test_shadow();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
